// File: rtl/mdu_iter.sv
// ============================================================================
//  Module   : mdu_iter
//  Purpose  : Iterative RV32M multiply/divide unit with start/busy/done
//             handshake. Define MDU_FAST_MUL_EN for a single-cycle multiplier.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int c_cw = $clog2(XLEN);
    localparam logic [c_cw-1:0] c_last = c_cw'(XLEN - 1);

    localparam logic [2:0] c_idle = 3'd0;
    localparam logic [2:0] c_mul  = 3'd1;
    localparam logic [2:0] c_div  = 3'd2;
    localparam logic [2:0] c_fix  = 3'd3;
    localparam logic [2:0] c_done = 3'd4;

`ifdef MDU_FAST_MUL_EN
    localparam logic [2:0] c_mul_go = c_done;
`else
    localparam logic [2:0] c_mul_go = c_mul;
`endif

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic              w_accept;
    logic [2:0]        r_op;
    logic [c_cw-1:0]   r_cnt;
    logic [c_cw-1:0]   w_cnt_nxt;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_opb;
    logic              r_negq;
    logic              r_negr;
    logic [XLEN-1:0]   r_result;

    // Operand conditioning for a new request
    logic            w_s1, w_s2, w_neg1, w_neg2;
    logic [XLEN-1:0] w_abs1, w_abs2;
    logic            w_div_zero, w_div_ovf, w_special;
    logic [XLEN-1:0] w_special_res;

    assign w_s1   = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3[2] && !funct3[0]);
    assign w_s2   = (funct3 == 3'b001) || (funct3[2] && !funct3[0]);
    assign w_neg1 = w_s1 && rs1[XLEN-1];
    assign w_neg2 = w_s2 && rs2[XLEN-1];
    assign w_abs1 = w_neg1 ? -rs1 : rs1;
    assign w_abs2 = w_neg2 ? -rs2 : rs2;

    assign w_div_zero = (rs2 == '0);
    assign w_div_ovf  = !funct3[0] && (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (&rs2);
    assign w_special  = funct3[2] && (w_div_zero || w_div_ovf);
    assign w_special_res = w_div_zero ? (funct3[1] ? rs1 : {XLEN{1'b1}})
                                      : (funct3[1] ? {XLEN{1'b0}} : rs1);

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] w_fa, w_fb, w_fast_prod;
    logic [XLEN-1:0]   w_fast_res;
    assign w_fa = {{XLEN{w_s1 & rs1[XLEN-1]}}, rs1};
    assign w_fb = {{XLEN{w_s2 & rs2[XLEN-1]}}, rs2};
    assign w_fast_prod = w_fa * w_fb;
    assign w_fast_res  = (funct3[1:0] == 2'b00) ? w_fast_prod[XLEN-1:0]
                                                : w_fast_prod[2*XLEN-1:XLEN];
`endif

    // Shift-add step: accumulator high half gathers the partial product,
    // low half holds the not-yet-consumed multiplier bits.
    logic [XLEN:0]     w_mul_sum;
    logic [2*XLEN-1:0] w_mul_nxt;
    assign w_mul_sum = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_nxt = {w_mul_sum, r_acc[XLEN-1:1]};

    // Restoring step: high half is the partial remainder, low half shifts
    // dividend bits out and quotient bits in.
    logic [XLEN:0]     w_div_sh, w_div_diff;
    logic [2*XLEN-1:0] w_div_nxt;
    assign w_div_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_div_diff = w_div_sh - {1'b0, r_opb};
    assign w_div_nxt  = w_div_diff[XLEN] ? {w_div_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                         : {w_div_diff[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};

    assign w_cnt_nxt = (r_cnt == c_last) ? '0 : r_cnt + 1'b1;

    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo, w_rem, w_fix_res;
    assign w_prod = r_negq ? -r_acc : r_acc;
    assign w_quo  = r_negq ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
    assign w_rem  = r_negr ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

    always_comb begin
        case (r_op)
            3'b000:                 w_fix_res = w_prod[XLEN-1:0];
            3'b001, 3'b010, 3'b011: w_fix_res = w_prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:         w_fix_res = w_quo;
            default:                w_fix_res = w_rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            c_idle, c_done: begin
                w_state_nxt = c_idle;
                if (start) begin
                    w_accept = 1'b1;
                    if (w_special)      w_state_nxt = c_done;
                    else if (funct3[2]) w_state_nxt = c_div;
                    else                w_state_nxt = c_mul_go;
                end
            end
            c_mul, c_div: begin
                if (r_cnt == c_last) w_state_nxt = c_fix;
            end
            c_fix:   w_state_nxt = c_done;
            default: w_state_nxt = c_idle;
        endcase
        // A flush wins over everything, including a same-cycle start.
        if (kill) begin
            w_state_nxt = c_idle;
            w_accept    = 1'b0;
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            c_mul, c_div, c_fix: busy = 1'b1;
            c_done:              done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_op     <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_negq   <= 1'b0;
            r_negr   <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_op   <= funct3;
            r_cnt  <= '0;
            r_negq <= w_neg1 ^ w_neg2;
            r_negr <= w_neg1;
            r_opb  <= funct3[2] ? w_abs2 : w_abs1;
            r_acc  <= {{XLEN{1'b0}}, (funct3[2] ? w_abs1 : w_abs2)};
            if (w_special) begin
                r_result <= w_special_res;
            end
`ifdef MDU_FAST_MUL_EN
            else if (!funct3[2]) begin
                r_result <= w_fast_res;
            end
`endif
        end else if (!kill) begin
            case (r_state)
                c_mul: begin
                    r_acc <= w_mul_nxt;
                    r_cnt <= w_cnt_nxt;
                end
                c_div: begin
                    r_acc <= w_div_nxt;
                    r_cnt <= w_cnt_nxt;
                end
                c_fix:   r_result <= w_fix_res;
                default: ;
            endcase
        end
    end

    assign result = r_result;

endmodule

`default_nettype wire

// File: tb/tb_mdu_iter.sv
// ============================================================================
//  Module   : tb_mdu_iter
//  Purpose  : Scoreboard bench for mdu_iter against an arithmetic reference.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mdu_iter;

    localparam int XLEN = 32;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        busy;
    logic        done;
    logic [31:0] result;

    exp_t        sb[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] last_res = '0;

    mdu_iter #(.XLEN(XLEN)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .kill   (kill),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sbv, ua, ub, p;
        logic               ovf;
        sa  = {{32{a[31]}}, a};
        sbv = {{32{b[31]}}, b};
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = ua * ub;  return p[31:0];  end
            3'd1: begin p = sa * sbv; return p[63:32]; end
            3'd2: begin p = sa * ub;  return p[63:32]; end
            3'd3: begin p = ua * ub;  return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf)    return a;
                return $signed(a) / $signed(b);
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                return a / b;
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf)    return 32'd0;
                return $signed(a) % $signed(b);
            end
            default: begin
                if (b == 0) return a;
                return a % b;
            end
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
        if (!f[2]) return 1;
`endif
        return XLEN + 2;
    endfunction

    // Monitor: every done pops one expectation and checks value and timing.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b1 && done === 1'b1) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: result %h, expected no done (cycle %0d)", result, cyc);
            end else begin
                e = sb.pop_front();
                chk("result", result, e.res);
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_in_done", {31'd0, busy}, 32'd0);
                last_res = e.res;
            end
        end
    end

    // Issues one op at the next falling edge, optionally pokes a stray start
    // at relative cycle poke_at, and waits for the scoreboard to drain.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        int   t0;
        int   lat;
        logic busy_bad;
        @(negedge clk);
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        t0  = cyc;
        lat = latency(f, a, b);
        sb.push_back('{ref_model(f, a, b), t0 + lat});
        busy_bad = 1'b0;
        for (int i = 1; i <= lat + 2; i++) begin
            @(negedge clk);
            if (i == poke_at) begin
                start = 1'b1; funct3 = 3'd0; rs1 = 32'd9; rs2 = 32'd9;
            end else begin
                start = 1'b0;
            end
            if (busy !== ((lat > 1) && (i < lat))) busy_bad = 1'b1;
        end
        chk("busy_window", {31'd0, busy_bad}, 32'd0);
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    // Second op is started in the DONE cycle of the first.
    task automatic run_b2b(input logic [2:0] fa, input logic [31:0] aa, input logic [31:0] ba,
                           input logic [2:0] fb, input logic [31:0] ab, input logic [31:0] bb);
        int lat_a;
        int lat_b;
        @(negedge clk);
        start = 1'b1; funct3 = fa; rs1 = aa; rs2 = ba;
        lat_a = latency(fa, aa, ba);
        lat_b = latency(fb, ab, bb);
        sb.push_back('{ref_model(fa, aa, ba), cyc + lat_a});
        for (int i = 1; i <= lat_a; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        start = 1'b1; funct3 = fb; rs1 = ab; rs2 = bb;
        sb.push_back('{ref_model(fb, ab, bb), cyc + lat_b});
        for (int i = 1; i <= lat_b + 2; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("b2b_drain", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        repeat (3) @(negedge clk);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", result, 32'd0);
        rst = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'd5, 32'd0, 0);
        run_op(3'd6, 32'd5, 32'd0, 0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);

        // Stray start in cycle 5 must be dropped
        run_op(3'd5, 32'd1000, 32'd13, 5);

        run_b2b(3'd0, 32'd7, 32'hFFFF_FFFD, 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);
        run_b2b(3'd5, 32'd5, 32'd0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_b2b(3'd4, 32'd77, 32'd5, 3'd6, 32'hFFFF_FF00, 32'd0);

        // kill and start together in idle: nothing starts
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd5; rs1 = 32'd50; rs2 = 32'd3;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        chk("kill_beats_start", {31'd0, busy}, 32'd0);

        // kill in cycle 10 of a divide
        @(negedge clk);
        start = 1'b1; funct3 = 3'd4; rs1 = 32'd12345; rs2 = 32'd17;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 10) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        chk("kill_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("kill_result_held", result, last_res);
        run_op(3'd7, 32'd12345, 32'd17, 0);

        // reset in cycle 20 of a divide
        @(negedge clk);
        start = 1'b1; funct3 = 3'd6; rs1 = 32'd999; rs2 = 32'd10;
        t0 = cyc;
        @(negedge clk);
        start = 1'b0;
        while (cyc < t0 + 20) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        last_res = '0;
        repeat (40) @(negedge clk);
        run_op(3'd1, 32'hFFFF_FFF0, 32'd3, 0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0)
                run_b2b(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(),
                        3'($urandom_range(0, 7)), rnd_operand(), rnd_operand());
            else
                run_op(3'($urandom_range(0, 7)), rnd_operand(), rnd_operand(), 0);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_iter.md
# mdu_iter

Iterative multiply/divide unit for the RV32M extension, sitting beside the ALU in the execute stage. It receives decoded M-extension operations from the control path as funct3 plus operands, executes them over multiple cycles with a start/busy/done handshake, and returns an XLEN result to writeback. It stalls the pipeline while busy.

## Interface
- XLEN, 32, operand/result width; must be even and at least 8.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  request; sampled only when busy=0.
- funct3  in  3  M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1  in  XLEN  operand A / dividend, captured with start.
- rs2  in  XLEN  operand B / divisor, captured with start.
- kill  in  1  flush; aborts any operation in flight.
- busy  out  1  operation in progress; pipeline stall.
- done  out  1  single-cycle pulse; result valid.
- result  out  XLEN  result; holds its last value until the next done.

## Operation
- Reset (rst=0 at an edge): state IDLE, busy=0, done=0, result=0, counter=0. Takes effect mid-operation, with no done.
- States: IDLE, MUL, DIV, FIX, DONE.
- IDLE/DONE with start=1 and kill=0: latch funct3, rs1, rs2.
  - Take magnitudes of signed operands: MULH both, MULHSU rs1 only, DIV/REM both.
  - Record the result-sign flag.
  - Go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
- MUL: shift-add over a 2·XLEN accumulator. XLEN iterations, counter 0..XLEN-1, then FIX.
- DIV: restoring division producing quotient and remainder. XLEN iterations, then FIX.
- FIX: apply sign correction.
  - Product: negate the 2·XLEN product if the sign flag is set.
  - Quotient: negated if the operand signs differ.
  - Remainder: takes the dividend's sign.
  - Select output: MUL takes the low XLEN bits; the MULH variants take the high XLEN bits; DIV/DIVU the quotient; REM/REMU the remainder.
  - Go to DONE.
- DONE: done=1 for one cycle, result updated. Next state is IDLE, or a new op if start=1.
- Divide special cases bypass iteration and go straight to DONE:
  - Divisor 0: DIV/DIVU → all ones; REM/REMU → rs1.
  - Signed overflow (rs1=100…0, rs2=all ones): DIV → rs1; REM → 0.
- start while busy=1 is ignored; the op is not queued.
- kill=1: next state is IDLE, busy=0, no done, result unchanged. kill beats start in the same cycle.

## Timing
- Cycle 0 is the cycle in which start is sampled high.
- Iterative ops:
  - busy=1 in cycles 1..XLEN+1: XLEN iteration cycles plus FIX.
  - done=1 and result valid in cycle XLEN+2 (34 for XLEN=32); busy=0 in that cycle.
- Divide special cases: done in cycle 1, busy=0 throughout.
- Back-to-back: start in the DONE cycle is accepted. Its done lands XLEN+2 cycles later, with no idle gap.
- done is registered, never combinational from start.
- kill in cycle k: busy=0 in cycle k+1.

## Configuration
- MDU_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 2·XLEN signed/unsigned multiply, registered at the end of cycle 0.
  - done in cycle 1, busy never asserted, MUL state unused.
  - Divide is unchanged.
- MDU_FAST_MUL_EN undefined: iterative multiply as above, with latency XLEN+2.

## Test plan
- MUL rs1=7, rs2=0xFFFFFFFD → result 0xFFFFFFEB, done in cycle 34 only, busy high cycles 1–33.
- rs1=rs2=0xFFFFFFFF: MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF.
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Special cases, each with done in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same operands → 0.
- Flush and reset:
  - start pulsed again in cycle 5 is ignored: exactly one done.
  - kill in cycle 10 → busy=0 in cycle 11, no done, result unchanged.
  - rst=0 in cycle 20 → all outputs 0 in cycle 21.
  - New start after either completes normally.
- With MDU_FAST_MUL_EN: MUL 7×(-3) → 0xFFFFFFEB with done in cycle 1; back-to-back MULs each complete in 1 cycle.
